// File: rtl/vex_pkg.sv
// Shared types and sizing for the Vex store, the read sequencer and the lattice PEs.
package vex_pkg;

  localparam int ADDR_W     = 13;
  localparam int DATA_W     = 64;
  localparam int LANES      = 4;
  localparam int RD_LAT     = 2;
  localparam int FIFO_DEPTH = 4;

  typedef struct packed {
    logic [LANES-1:0][DATA_W-1:0] data;
    logic [LANES-1:0]             mask;
    logic                         last;
  } beat_t;

  typedef struct packed {
    logic             vld;
    logic [LANES-1:0] mask;
    logic             last;
  } tag_t;

  // Lane mask for the final beat of a sweep; rem == 0 means the beat is full.
  function automatic logic [LANES-1:0] tail_mask(input logic [1:0] rem);
    return (rem == 2'd0) ? '1 : LANES'((1 << rem) - 1);
  endfunction

endpackage

// File: rtl/vex_reader_if.sv
// Store read port plus the downstream beat stream of the Vex read sequencer.
interface vex_reader_if;
  import vex_pkg::*;

  logic [ADDR_W-1:0] vexaddr;
  logic [DATA_W-1:0] chan0, chan1, chan2, chan3;
  logic [DATA_W-1:0] out_data0, out_data1, out_data2, out_data3;
  logic [LANES-1:0]  out_mask;
  logic              out_last;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output vexaddr,
    input  chan0, chan1, chan2, chan3,
    output out_data0, out_data1, out_data2, out_data3,
    output out_mask, out_last, out_valid,
    input  out_ready
  );

  modport slave (
    input  vexaddr,
    output chan0, chan1, chan2, chan3,
    input  out_data0, out_data1, out_data2, out_data3,
    input  out_mask, out_last, out_valid,
    output out_ready
  );

endinterface

// File: rtl/vex_beat_fifo.sv
// Skid FIFO holding captured beats until downstream accepts them.
module vex_beat_fifo
  import vex_pkg::*;
#(
  parameter  int DEPTH = FIFO_DEPTH,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             push,
  input  beat_t            din,
  input  logic             pop,
  output beat_t            dout,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  beat_t            mem_q [DEPTH];
  beat_t            mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = next_ptr(wr_ptr_q);
    end
    if (do_pop) rd_ptr_d = next_ptr(rd_ptr_q);
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/vex_reader.sv
// Sweeps a range of Vex entries from the fixed-latency store and forwards 4-wide beats.
//   state   | meaning
//   IDLE    | waiting for start; an accepted start issues the first address at once
//   ISSUE   | issuing one address per cycle while credit allows
//   DRAIN   | all issued; waiting for in-flight and buffered beats to be accepted
//   DONE    | sweep finished; done pulses next cycle
module vex_reader
  import vex_pkg::*;
(
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] num_nodes,
  output logic              busy,
  output logic              done,
  vex_reader_if.master      bus
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int BEAT_W = ADDR_W - 1;
  localparam logic [CNT_W-1:0] OCC_MAX = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d, vexaddr_q, vexaddr_d;
  logic [BEAT_W-1:0] beats_q, beats_d;
  logic [1:0]        rem_q, rem_d;
  logic [CNT_W-1:0]  occ_q, occ_d;
  logic              busy_q, busy_d, done_q, done_d;
  tag_t              tag_q [RD_LAT+1];
  tag_t              tag_d [RD_LAT+1];

  logic [BEAT_W-1:0] n_beats;
  logic [ADDR_W-1:0] issue_addr;
  logic [LANES-1:0]  issue_mask;
  logic [CNT_W-1:0]  fifo_count;
  logic              accept, issue, issue_last, push, pop, fifo_empty;
  beat_t             fifo_din, fifo_dout, head;

  assign n_beats = BEAT_W'(num_nodes >> 2) + BEAT_W'(num_nodes[1:0] != 2'd0);
  assign accept  = (state_q == S_IDLE) && start && !done_q;
  assign pop     = !fifo_empty && bus.out_ready;
  assign push    = tag_q[RD_LAT].vld;

  // occ_q counts every issued beat until it is popped, so it bounds in-flight plus buffered.
  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    beats_d    = beats_q;
    rem_d      = rem_q;
    busy_d     = busy_q;
    done_d     = (state_q == S_DONE);
    issue      = 1'b0;
    issue_addr = cur_addr_q;
    issue_last = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          busy_d = 1'b1;
          rem_d  = num_nodes[1:0];
          if (num_nodes == '0) begin
            state_d = S_DONE;
          end else begin
            issue      = 1'b1;
            issue_addr = first_addr;
            issue_last = (n_beats == BEAT_W'(1));
            cur_addr_d = first_addr + ADDR_W'(4);
            beats_d    = n_beats - BEAT_W'(1);
            state_d    = issue_last ? S_DRAIN : S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if ((occ_q < OCC_MAX) || pop) begin
          issue      = 1'b1;
          issue_last = (beats_q == BEAT_W'(1));
          cur_addr_d = cur_addr_q + ADDR_W'(4);
          beats_d    = beats_q - BEAT_W'(1);
          if (issue_last) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((occ_q == fifo_count) &&
            ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop)))
          state_d = S_DONE;
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    issue_mask = issue_last ? tail_mask(accept ? num_nodes[1:0] : rem_q) : '1;
    vexaddr_d  = issue ? issue_addr : vexaddr_q;
    occ_d      = occ_q + CNT_W'(issue) - CNT_W'(pop);

    tag_d[0].vld  = issue;
    tag_d[0].mask = issue_mask;
    tag_d[0].last = issue_last;
    for (int i = 1; i <= RD_LAT; i++) tag_d[i] = tag_q[i-1];
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= S_IDLE;
      cur_addr_q <= '0;
      vexaddr_q  <= '0;
      beats_q    <= '0;
      rem_q      <= '0;
      occ_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      for (int i = 0; i <= RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      vexaddr_q  <= vexaddr_d;
      beats_q    <= beats_d;
      rem_q      <= rem_d;
      occ_q      <= occ_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      for (int i = 0; i <= RD_LAT; i++) tag_q[i] <= tag_d[i];
    end
  end

  assign fifo_din = '{data: {bus.chan3, bus.chan2, bus.chan1, bus.chan0},
                      mask: tag_q[RD_LAT].mask,
                      last: tag_q[RD_LAT].last};

  vex_beat_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Outputs read as zero whenever no beat is presented.
  assign head          = fifo_empty ? '0 : fifo_dout;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_data0 = head.data[0];
  assign bus.out_data1 = head.data[1];
  assign bus.out_data2 = head.data[2];
  assign bus.out_data3 = head.data[3];
  assign bus.out_mask  = head.mask;
  assign bus.out_last  = head.last;
  assign bus.vexaddr   = vexaddr_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_vex_reader.sv
// Scoreboard bench for vex_reader: directed sweeps against a 2-cycle store model.
module tb_vex_reader;
  import vex_pkg::*;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [3:0]        mask;
    logic              last;
  } exp_t;

  logic              clk = 1'b0;
  logic              nrst = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] first_addr = '0;
  logic [ADDR_W-1:0] num_nodes = '0;
  logic              busy, done;
  logic [ADDR_W-1:0] a1, a2, prev_va;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_acc_cyc = 0;
  int   valid_cnt = 0;
  int   va_changes = 0;

  vex_reader_if bus();

  vex_reader dut (
    .clk        (clk),
    .nrst       (nrst),
    .start      (start),
    .first_addr (first_addr),
    .num_nodes  (num_nodes),
    .busy       (busy),
    .done       (done),
    .bus        (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DATA_W-1:0] ent(input logic [ADDR_W-1:0] a);
    return {16'hA5A5, 35'd0, a};
  endfunction

  // Store model: data for vexaddr appears RD_LAT cycles after vexaddr changes.
  always @(posedge clk) begin
    a1 <= bus.vexaddr;
    a2 <= a1;
  end
  assign bus.chan0 = ent(a2);
  assign bus.chan1 = ent(a2 + ADDR_W'(1));
  assign bus.chan2 = ent(a2 + ADDR_W'(2));
  assign bus.chan3 = ent(a2 + ADDR_W'(3));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [ADDR_W-1:0] a, input logic [3:0] m, input logic l);
    exp_t e;
    e.addr = a;
    e.mask = m;
    e.last = l;
    sbq.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_sweep(input logic [ADDR_W-1:0] fa, input logic [ADDR_W-1:0] n);
    first_addr = fa;
    num_nodes  = n;
    start      = 1'b1;
    step();
    start      = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    check("done_seen", 64'(done), 64'd1);
    if (done === 1'b1)
      check("done_after_last_accept",
            64'((cyc - last_acc_cyc >= 1) && (cyc - last_acc_cyc <= 2)), 64'd1);
  endtask

  task automatic finish_sweep(input int budget);
    wait_done(budget);
    step();
    check("done_one_cycle", 64'(done), 64'd0);
    check("busy_after_done", 64'(busy), 64'd0);
    check("scoreboard_drained", 64'(sbq.size()), 64'd0);
  endtask

  // Monitor: pops the scoreboard whenever a beat is accepted.
  always @(negedge clk) begin
    exp_t e;
    if (bus.vexaddr != prev_va) va_changes++;
    prev_va = bus.vexaddr;
    if (bus.out_valid) valid_cnt++;
    if (nrst && bus.out_valid && bus.out_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat actual_lane0=%h required=no_beat", bus.out_data0);
      end else begin
        e = sbq.pop_front();
        check("beat_mask", 64'(bus.out_mask), 64'(e.mask));
        check("beat_last", 64'(bus.out_last), 64'(e.last));
        check("beat_lane0", bus.out_data0, ent(e.addr));
        check("beat_lane1", bus.out_data1, ent(e.addr + ADDR_W'(1)));
        check("beat_lane2", bus.out_data2, ent(e.addr + ADDR_W'(2)));
        check("beat_lane3", bus.out_data3, ent(e.addr + ADDR_W'(3)));
        if (bus.out_last) last_acc_cyc = cyc;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int base, done_at;
    bus.out_ready = 1'b1;
    repeat (2) step();

    check("rst_vexaddr", 64'(bus.vexaddr), 64'h0);
    check("rst_out_valid", 64'(bus.out_valid), 64'h0);
    check("rst_out_mask", 64'(bus.out_mask), 64'h0);
    check("rst_out_last", 64'(bus.out_last), 64'h0);
    check("rst_out_data0", bus.out_data0, 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_done", 64'(done), 64'h0);
    nrst = 1'b1;
    step();

    // 8 entries from 0x100: two full beats
    push_exp(13'h100, 4'hF, 1'b0);
    push_exp(13'h104, 4'hF, 1'b1);
    start_sweep(13'h100, 13'd8);
    check("t1_vexaddr0", 64'(bus.vexaddr), 64'h100);
    check("t1_busy", 64'(busy), 64'd1);
    step();
    check("t1_vexaddr1", 64'(bus.vexaddr), 64'h104);
    finish_sweep(40);

    // 6 entries: partial final beat, lanes 0-1 valid
    push_exp(13'h100, 4'hF, 1'b0);
    push_exp(13'h104, 4'h3, 1'b1);
    start_sweep(13'h100, 13'd6);
    finish_sweep(40);

    // 32 entries with downstream stalled: credit caps issue at FIFO_DEPTH
    bus.out_ready = 1'b0;
    for (int b = 0; b < 8; b++) push_exp(13'h200 + 13'(4 * b), 4'hF, b == 7);
    base = va_changes;
    start_sweep(13'h200, 13'd32);
    repeat (12) step();
    check("t3_issue_count", 64'(va_changes - base), 64'd4);
    check("t3_vexaddr_frozen", 64'(bus.vexaddr), 64'h20C);
    repeat (5) step();
    check("t3_vexaddr_still", 64'(bus.vexaddr), 64'h20C);
    check("t3_out_valid", 64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b1;
    finish_sweep(80);

    // address wrap at 2^ADDR_W
    push_exp(13'h1FFE, 4'hF, 1'b0);
    push_exp(13'h0002, 4'hF, 1'b1);
    start_sweep(13'h1FFE, 13'd8);
    check("t4_vexaddr0", 64'(bus.vexaddr), 64'h1FFE);
    step();
    check("t4_vexaddr1", 64'(bus.vexaddr), 64'h0002);
    finish_sweep(40);

    // zero-length sweep
    base = valid_cnt;
    done_at = 0;
    start_sweep(13'h010, 13'd0);
    if (done) done_at = 1;
    for (int k = 2; k <= 5; k++) begin
      step();
      if (done && done_at == 0) done_at = k;
    end
    check("t5_done_at", 64'(done_at), 64'd2);
    check("t5_no_valid", 64'(valid_cnt - base), 64'd0);

    // start during a sweep and in the done cycle are both ignored
    push_exp(13'h300, 4'hF, 1'b0);
    push_exp(13'h304, 4'hF, 1'b1);
    start_sweep(13'h300, 13'd8);
    first_addr = 13'h700;
    num_nodes  = 13'd4;
    start      = 1'b1;
    step();
    start      = 1'b0;
    wait_done(40);
    first_addr = 13'h500;
    num_nodes  = 13'd4;
    start      = 1'b1;
    step();
    start      = 1'b0;
    check("t5_busy_after_done_start", 64'(busy), 64'd0);
    repeat (3) step();
    check("t5_busy_idle", 64'(busy), 64'd0);
    check("t5_vexaddr_kept", 64'(bus.vexaddr), 64'h304);
    check("t5_sb_empty", 64'(sbq.size()), 64'd0);

    // reset with two beats in flight
    start_sweep(13'h400, 13'd16);
    step();
    nrst = 1'b0;
    #1;
    check("t6_rst_vexaddr", 64'(bus.vexaddr), 64'h0);
    check("t6_rst_out_valid", 64'(bus.out_valid), 64'h0);
    check("t6_rst_out_mask", 64'(bus.out_mask), 64'h0);
    check("t6_rst_out_last", 64'(bus.out_last), 64'h0);
    check("t6_rst_out_data0", bus.out_data0, 64'h0);
    check("t6_rst_busy", 64'(busy), 64'h0);
    check("t6_rst_done", 64'(done), 64'h0);
    base = valid_cnt;
    repeat (2) step();
    nrst = 1'b1;
    repeat (4) step();
    check("t6_no_stale_valid", 64'(valid_cnt - base), 64'd0);
    push_exp(13'h600, 4'hF, 1'b0);
    push_exp(13'h604, 4'h1, 1'b1);
    start_sweep(13'h600, 13'd5);
    finish_sweep(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
